pipe_wb_regfile: RTL

//  Writeback stage of the five-stage pipeline, directly downstream of the MEM/WB register.
//  It selects the writeback data from the memory read data or the ALU result.
//  It commits that data to a 32-entry register file and provides two combinational read ports to the ID stage.
//  A commit counter is provided for bench and debug visibility.

---
 rtl/pipe_wb_regfile_if.sv | 29 ++
 rtl/pipe_wb_regfile.sv | 59 +++++
 2 files changed

// File: rtl/pipe_wb_regfile_if.sv
// Bus between the MEM/WB register, the ID stage and the writeback register file.
// master: pipeline side driving writeback/read indices; slave: the register file.
interface pipe_wb_regfile_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 32
);
   logic              wwreg;
   logic              wm2reg;
   logic [DATA_W-1:0] wmo;
   logic [DATA_W-1:0] walu;
   logic [ADDR_W-1:0] wrn;
   logic [ADDR_W-1:0] rna;
   logic [ADDR_W-1:0] rnb;
   logic [DATA_W-1:0] qa;
   logic [DATA_W-1:0] qb;
   logic [DATA_W-1:0] wdi;
   logic [CNT_W-1:0]  wb_count;

   modport master (
      output wwreg, wm2reg, wmo, walu, wrn, rna, rnb,
      input  qa, qb, wdi, wb_count
   );

   modport slave (
      input  wwreg, wm2reg, wmo, walu, wrn, rna, rnb,
      output qa, qb, wdi, wb_count
   );
endinterface

// File: rtl/pipe_wb_regfile.sv
// Writeback stage: result select, 32-entry register file with r0 hardwired to zero, commit counter.
// Optional REGFILE_BYPASS_EN: same-cycle write-through of the WB result onto the read ports.
module pipe_wb_regfile #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 32
) (
   input logic              clk,
   input logic              clr,
   pipe_wb_regfile_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs [DEPTH];
   logic [DATA_W-1:0] wdi;
   logic [DATA_W-1:0] qa;
   logic [DATA_W-1:0] qb;
   logic [CNT_W-1:0]  wb_count;
   logic              commit;

   assign wdi    = bus.wm2reg ? bus.wmo : bus.walu;
   assign commit = bus.wwreg && (bus.wrn != '0);

   // Entry 0 is cleared on reset and never written, so it stays zero.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         wb_count <= '0;
      end else if (commit) begin
         regs[bus.wrn] <= wdi;
         wb_count      <= wb_count + CNT_W'(1);
      end
   end

   always_comb begin
      qa = '0;
      if (!clr && (bus.rna != '0)) begin
         qa = regs[bus.rna];
`ifdef REGFILE_BYPASS_EN
         if (commit && (bus.rna == bus.wrn)) qa = wdi;
`endif
      end
   end

   always_comb begin
      qb = '0;
      if (!clr && (bus.rnb != '0)) begin
         qb = regs[bus.rnb];
`ifdef REGFILE_BYPASS_EN
         if (commit && (bus.rnb == bus.wrn)) qb = wdi;
`endif
      end
   end

   assign bus.wdi      = wdi;
   assign bus.qa       = qa;
   assign bus.qb       = qb;
   assign bus.wb_count = wb_count;
endmodule
